// File: rtl/piano_keypad_poly.sv
// Polyphonic keypad mapper: turns the scanner's ready/keycode stream into up
// to VOICES note/octave pairs, with a saturating octave register, a panic key
// and a runtime momentary/latch (toggle) mode.
//
// Ports:
//   clk      - clock
//   rst      - synchronous active-high reset
//   ready    - scanner reports a held key
//   keycode  - key index, valid while ready is high
//   latch    - 0 = momentary mode, 1 = latch mode
//   notes    - voice i note in [4i+3:4i], 0 = rest, 1..12 = C..B
//   octaves  - octave captured at allocation of voice i, 0 when inactive
//   active   - bit i high while voice i sounds
//   octave   - current octave register
//   changed  - one-cycle pulse on any change of notes/octaves/active
module piano_keypad_poly #(
  parameter int unsigned VOICES    = 4,
  parameter int unsigned OCT_MIN   = 0,
  parameter int unsigned OCT_MAX   = 9,
  parameter int unsigned OCT_RESET = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ready,
  input  logic [4:0]            keycode,
  input  logic                  latch,
  output logic [4*VOICES-1:0]   notes,
  output logic [4*VOICES-1:0]   octaves,
  output logic [VOICES-1:0]     active,
  output logic [3:0]            octave,
  output logic                  changed
);

  localparam int unsigned NW = 4 * VOICES;
  localparam int unsigned PW = (VOICES > 1) ? $clog2(VOICES) : 1;

  localparam logic [4:0] KEY_OCT_UP   = 5'd15;
  localparam logic [4:0] KEY_OCT_DOWN = 5'd19;
  localparam logic [4:0] KEY_PANIC    = 5'd18;

  logic          ready_q;
  logic [4:0]    keycode_q;
  logic          latch_q;
  logic [PW-1:0] steal_ptr;

  logic          press;
  logic          release_ev;
  logic          latch_fall;
  logic [3:0]    key_note;
  logic [4:0]    oct5;

  logic [NW-1:0]     nxt_notes;
  logic [NW-1:0]     nxt_octaves;
  logic [VOICES-1:0] nxt_active;
  logic [3:0]        nxt_octave;
  logic [PW-1:0]     nxt_steal;
  logic              nxt_changed;

  logic              hit;
  logic [PW-1:0]     hit_idx;
  logic              free;
  logic [PW-1:0]     free_idx;

  // Keypad position to note number; 0 marks a non-note key.
  function automatic logic [3:0] map_key(input logic [4:0] k);
    case (k)
      5'd4:    map_key = 4'd1;
      5'd8:    map_key = 4'd2;
      5'd5:    map_key = 4'd3;
      5'd9:    map_key = 4'd4;
      5'd6:    map_key = 4'd5;
      5'd7:    map_key = 4'd6;
      5'd11:   map_key = 4'd7;
      5'd12:   map_key = 4'd8;
      5'd16:   map_key = 4'd9;
      5'd13:   map_key = 4'd10;
      5'd17:   map_key = 4'd11;
      5'd14:   map_key = 4'd12;
      default: map_key = 4'd0;
    endcase
  endfunction

  // Event detection; a keycode change under a held ready counts as a new press.
  always_comb begin
    press      = ready & (~ready_q | (keycode != keycode_q));
    release_ev = ~ready & ready_q;
    latch_fall = latch_q & ~latch;
    key_note   = map_key(keycode);
    oct5       = {1'b0, octave};
  end

  // Next-state computation for voices, octave and steal pointer.
  always_comb begin
    nxt_notes   = notes;
    nxt_octaves = octaves;
    nxt_active  = active;
    nxt_octave  = octave;
    nxt_steal   = steal_ptr;
    hit         = 1'b0;
    hit_idx     = '0;
    free        = 1'b0;
    free_idx    = '0;

    if (latch_fall) begin
      nxt_notes   = '0;
      nxt_octaves = '0;
      nxt_active  = '0;
    end

    // Octave steps saturate; the 5-bit compare keeps the down-step from wrapping.
    if (press && keycode == KEY_OCT_UP) begin
      if (oct5 < 5'(OCT_MAX)) nxt_octave = 4'(oct5 + 5'd1);
    end
    if (press && keycode == KEY_OCT_DOWN) begin
      if (oct5 > 5'(OCT_MIN)) nxt_octave = 4'(oct5 - 5'd1);
    end

    if (press && keycode == KEY_PANIC) begin
      nxt_notes   = '0;
      nxt_octaves = '0;
      nxt_active  = '0;
    end

    if (!latch) begin
      if (press || release_ev) begin
        nxt_notes   = '0;
        nxt_octaves = '0;
        nxt_active  = '0;
      end
      if (press && key_note != 4'd0) begin
        nxt_notes[3:0]   = key_note;
        nxt_octaves[3:0] = octave;
        nxt_active[0]    = 1'b1;
      end
    end else if (press && key_note != 4'd0) begin
      for (int i = 0; i < int'(VOICES); i++) begin
        if (!hit && active[i] && notes[4*i +: 4] == key_note &&
            octaves[4*i +: 4] == octave) begin
          hit     = 1'b1;
          hit_idx = PW'(i);
        end
        if (!free && !active[i]) begin
          free     = 1'b1;
          free_idx = PW'(i);
        end
      end
      if (hit) begin
        nxt_notes[4*int'(hit_idx) +: 4]   = 4'd0;
        nxt_octaves[4*int'(hit_idx) +: 4] = 4'd0;
        nxt_active[hit_idx]               = 1'b0;
      end else if (free) begin
        nxt_notes[4*int'(free_idx) +: 4]   = key_note;
        nxt_octaves[4*int'(free_idx) +: 4] = octave;
        nxt_active[free_idx]               = 1'b1;
      end else begin
        nxt_notes[4*int'(steal_ptr) +: 4]   = key_note;
        nxt_octaves[4*int'(steal_ptr) +: 4] = octave;
        nxt_active[steal_ptr]               = 1'b1;
        nxt_steal = (steal_ptr == PW'(VOICES - 1)) ? '0 : PW'(steal_ptr + PW'(1));
      end
    end

    nxt_changed = (nxt_notes != notes) || (nxt_octaves != octaves) ||
                  (nxt_active != active);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      notes     <= '0;
      octaves   <= '0;
      active    <= '0;
      octave    <= 4'(OCT_RESET);
      changed   <= 1'b0;
      steal_ptr <= '0;
      ready_q   <= 1'b0;
      keycode_q <= '0;
      latch_q   <= 1'b0;
    end else begin
      notes     <= nxt_notes;
      octaves   <= nxt_octaves;
      active    <= nxt_active;
      octave    <= nxt_octave;
      changed   <= nxt_changed;
      steal_ptr <= nxt_steal;
      ready_q   <= ready;
      keycode_q <= keycode;
      latch_q   <= latch;
    end
  end

endmodule

// File: tb/tb_piano_keypad_poly.sv
// Directed bench for piano_keypad_poly with hand-computed expectations.
module tb_piano_keypad_poly;

  logic        clk;
  logic        rst;
  logic        ready;
  logic [4:0]  keycode;
  logic        latch;
  logic [15:0] notes;
  logic [15:0] octaves;
  logic [3:0]  active;
  logic [3:0]  octave;
  logic        changed;

  int checks = 0;
  int errors = 0;

  piano_keypad_poly #(
    .VOICES(4), .OCT_MIN(0), .OCT_MAX(9), .OCT_RESET(4)
  ) dut (
    .clk(clk), .rst(rst), .ready(ready), .keycode(keycode), .latch(latch),
    .notes(notes), .octaves(octaves), .active(active), .octave(octave),
    .changed(changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [4:0] k);
    ready = 1'b1;
    keycode = k;
    step();
  endtask

  task automatic release_key();
    ready = 1'b0;
    step();
  endtask

  initial begin
    logic [3:0] exp_oct;
    rst = 1'b1; ready = 1'b0; keycode = '0; latch = 1'b0;
    step(); step();
    rst = 1'b0;
    check("rst_notes", 32'(notes), 32'h0);
    check("rst_octaves", 32'(octaves), 32'h0);
    check("rst_active", 32'(active), 32'h0);
    check("rst_octave", 32'(octave), 32'd4);
    check("rst_changed", 32'(changed), 32'd0);

    // Momentary hold of key 4 for 5 cycles.
    press(5'd4);
    check("mom_note", 32'(notes[3:0]), 32'd1);
    check("mom_oct", 32'(octaves[3:0]), 32'd4);
    check("mom_active", 32'(active), 32'b0001);
    check("mom_changed", 32'(changed), 32'd1);
    step();
    check("mom_changed_once", 32'(changed), 32'd0);
    step(); step(); step();
    check("mom_hold_active", 32'(active), 32'b0001);
    release_key();
    check("mom_rel_active", 32'(active), 32'b0000);
    check("mom_rel_notes", 32'(notes), 32'h0);
    check("mom_rel_changed", 32'(changed), 32'd1);
    step();
    check("mom_rel_changed_once", 32'(changed), 32'd0);

    // Octave up saturates at 9.
    exp_oct = 4'd4;
    for (int i = 0; i < 8; i++) begin
      press(5'd15);
      exp_oct = (exp_oct < 4'd9) ? exp_oct + 4'd1 : 4'd9;
      check("oct_up", 32'(octave), 32'(exp_oct));
      release_key();
    end
    check("oct_up_sat", 32'(octave), 32'd9);
    // Held octave key does not repeat.
    press(5'd19);
    step(); step();
    check("oct_no_repeat", 32'(octave), 32'd8);
    release_key();
    exp_oct = 4'd8;
    for (int i = 0; i < 11; i++) begin
      press(5'd19);
      exp_oct = (exp_oct > 4'd0) ? exp_oct - 4'd1 : 4'd0;
      check("oct_down", 32'(octave), 32'(exp_oct));
      release_key();
    end
    check("oct_down_sat", 32'(octave), 32'd0);
    for (int i = 0; i < 4; i++) begin
      press(5'd15);
      release_key();
    end
    check("oct_restore", 32'(octave), 32'd4);
    check("oct_no_voice", 32'(active), 32'd0);

    // Latch mode: allocate four voices, then steal and toggle.
    latch = 1'b1;
    step();
    press(5'd4); release_key();
    press(5'd5); release_key();
    press(5'd6); release_key();
    press(5'd7); release_key();
    check("latch_active4", 32'(active), 32'b1111);
    check("latch_notes4", 32'(notes), 32'h6531);
    check("latch_octs4", 32'(octaves), 32'h4444);
    press(5'd12);
    check("steal_notes", 32'(notes), 32'h6538);
    check("steal_ptr", 32'(dut.steal_ptr), 32'd1);
    check("steal_changed", 32'(changed), 32'd1);
    release_key();
    check("latch_rel_noeffect", 32'(changed), 32'd0);
    press(5'd12);
    check("toggle_active", 32'(active), 32'b1110);
    check("toggle_notes", 32'(notes), 32'h6530);
    check("toggle_octs", 32'(octaves), 32'h4440);
    release_key();
    press(5'd3);
    check("unmapped_latch_active", 32'(active), 32'b1110);
    check("unmapped_latch_changed", 32'(changed), 32'd0);
    release_key();

    // Panic with two latched voices.
    press(5'd18); release_key();
    check("panic_pre", 32'(active), 32'd0);
    press(5'd4); release_key();
    press(5'd5); release_key();
    check("two_latched", 32'(notes), 32'h0031);
    check("two_active", 32'(active), 32'b0011);
    press(5'd18);
    check("panic_active", 32'(active), 32'd0);
    check("panic_notes", 32'(notes), 32'h0);
    check("panic_octs", 32'(octaves), 32'h0);
    check("panic_steal_kept", 32'(dut.steal_ptr), 32'd1);
    release_key();
    press(5'd4); release_key();
    check("relatch", 32'(active), 32'b0001);
    latch = 1'b0;
    step();
    check("latch_fall_active", 32'(active), 32'd0);
    check("latch_fall_notes", 32'(notes), 32'h0);
    check("latch_fall_changed", 32'(changed), 32'd1);

    // Latch drop in the same cycle as a press: clear, then momentary load.
    latch = 1'b1;
    step();
    press(5'd4); release_key();
    check("pre_fall_press", 32'(active), 32'b0001);
    latch = 1'b0;
    press(5'd5);
    check("fall_press_notes", 32'(notes), 32'h0003);
    check("fall_press_active", 32'(active), 32'b0001);
    release_key();
    check("fall_press_rel", 32'(active), 32'd0);

    // Keycode change while ready held.
    press(5'd4);
    step();
    check("kc_hold", 32'(notes[3:0]), 32'd1);
    keycode = 5'd13;
    step();
    check("kc_switch_note", 32'(notes[3:0]), 32'd10);
    check("kc_switch_active", 32'(active), 32'b0001);
    check("kc_switch_changed", 32'(changed), 32'd1);
    step();
    check("kc_switch_once", 32'(changed), 32'd0);
    release_key();

    // Reset mid-hold in latch mode.
    latch = 1'b1;
    step();
    press(5'd6);
    check("pre_rst_note", 32'(notes), 32'h0005);
    rst = 1'b1;
    step();
    check("mid_rst_notes", 32'(notes), 32'h0);
    check("mid_rst_octs", 32'(octaves), 32'h0);
    check("mid_rst_active", 32'(active), 32'h0);
    check("mid_rst_octave", 32'(octave), 32'd4);
    check("mid_rst_changed", 32'(changed), 32'd0);
    check("mid_rst_steal", 32'(dut.steal_ptr), 32'd0);
    rst = 1'b0;
    step();
    check("post_rst_note", 32'(notes), 32'h0005);
    check("post_rst_oct", 32'(octaves), 32'h0004);
    check("post_rst_active", 32'(active), 32'b0001);
    check("post_rst_changed", 32'(changed), 32'd1);
    release_key();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/piano_keypad_poly.md
# piano_keypad_poly

Parametrised polyphonic successor to the single-note keypad mapper. It sits between the keypad scanner and the tone generators. It converts the scanner's `ready`/`keycode` stream into up to `VOICES` simultaneous note/octave pairs, with a saturating octave register and a runtime latch (toggle) mode. All state is clocked; press and release are edge-detected inside the block.

## Interface
- `VOICES`, 4: number of voice slots, 1..8.
- `OCT_MIN`, 0: lowest octave.
- `OCT_MAX`, 9: highest octave; must be ≤ 15 and ≥ `OCT_MIN`.
- `OCT_RESET`, 4: octave after reset; must lie within `OCT_MIN`..`OCT_MAX`.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `ready` in 1: high while the scanner reports a held key.
- `keycode` in 5: key index, valid while `ready` is high.
- `latch` in 1: 0 selects momentary mode, 1 selects latch mode.
- `notes` out 4·VOICES: voice i occupies `[4i+3:4i]`; 0 = rest, 1..12 = C..B.
- `octaves` out 4·VOICES: octave captured when voice i was allocated; 0 when the voice is inactive.
- `active` out VOICES: bit i high while voice i sounds.
- `octave` out 4: current octave register.
- `changed` out 1: one-cycle pulse on any change to `notes`, `octaves` or `active`.

## Operation
- Key map:
  - 4→1 (C), 8→2, 5→3, 9→4, 6→5, 7→6, 11→7, 12→8, 13→10, 16→9, 17→11, 14→12.
  - 15 = octave up, 19 = octave down, 18 = panic.
  - All other codes are unmapped.
- Edge detection: `ready_q` and `keycode_q` are registered every cycle.
  - Press event: `ready & (~ready_q | keycode != keycode_q)`.
  - Release event: `~ready & ready_q`.
- Octave keys: one step per press event, saturating at `OCT_MAX` / `OCT_MIN`.
  - Compute in ≥5 bits; down-step at `OCT_MIN` must not wrap.
  - A held key never auto-repeats.
  - Octave keys do not affect voices that are already sounding.
- Panic (18), either mode: all voices are cleared (`active` = 0, `notes` = 0, `octaves` = 0). `steal_ptr` is kept.
- Momentary mode (`latch` = 0):
  - Any press or release event first clears all voices.
  - A note-key press then loads voice 0 with the note and the current `octave`, and sets `active[0]`.
  - At most voice 0 is ever active.
- Latch mode (`latch` = 1), note-key press:
  - If some active voice holds the same note and octave, that voice is cleared (toggle off).
  - Otherwise the lowest-index inactive voice is allocated.
  - If no voice is inactive, the voice at `steal_ptr` is overwritten and `steal_ptr` increments modulo `VOICES`. `steal_ptr` changes only on a steal.
  - Release events have no effect.
- Latch falling edge (`latch_q & ~latch`): all voices are cleared.
  - If a press occurs in the same cycle, the clear is applied first, then the press is processed in momentary mode.
- Unmapped-key press:
  - Momentary mode: only the clear is applied.
  - Latch mode: no effect.

## Timing
- Reset values: `notes` = 0, `octaves` = 0, `active` = 0, `octave` = `OCT_RESET`, `changed` = 0, `steal_ptr` = 0, `ready_q` = 0, `keycode_q` = 0, `latch_q` = 0.
- Latency: an event sampled at edge N is visible on all outputs after edge N. `changed` is high for exactly that cycle.
- `rst` has priority over every event. Reset asserted mid-hold clears all state.
  - After reset deassertion, a still-held key (`ready` = 1, `ready_q` = 0) counts as a fresh press.
- A keycode change while `ready` stays high is one press event. No release event is generated for the previous key; in momentary mode the implied clear covers it.
- All outputs are registers; no combinational path from inputs to outputs.

## Test plan
- Reset, then `latch` = 0; hold key 4 for 5 cycles, then release:
  - One cycle after the press: `notes[3:0]` = 1, `octaves[3:0]` = 4, `active` = 0001, `changed` pulses once.
  - One cycle after the release: `active` = 0000.
- Press key 15 eight times (each with a release):
  - `octave` steps 5, 6, 7, 8, 9 and then stays at 9.
  - Then press key 19 twelve times: `octave` reaches 0 and stays at 0, with no wrap to 15.
- `latch` = 1; press keys 4, 5, 6, 7 in turn, then 12:
  - After the four presses, `active` = 1111.
  - Key 12 overwrites voice 0 with note 8, and `steal_ptr` becomes 1.
  - Pressing 12 again clears voice 0.
- `latch` = 1 with keys 4 and 5 latched:
  - Press 18: `active` = 0000 and `notes` = 0.
  - Re-latch key 4, then drop `latch` to 0: all voices are cleared on the next edge.
- `latch` = 0; hold key 4, then switch `keycode` to 13 with `ready` held high:
  - Voice 0 changes 1→10 in a single cycle, and `changed` pulses once.
- Assert `rst` while key 6 is held in latch mode:
  - All outputs return to their reset values.
  - After deassertion, the still-held key allocates voice 0 with note 5 and octave 4.
